// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants for the ALU arbiter: opcode values, FSM state
//             encoding and the default datapath width.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  // ALU opcodes; values 5..7 are passed through to the ALU untouched.
  localparam int unsigned ALU_ADD    = 0;
  localparam int unsigned ALU_SUB    = 1;
  localparam int unsigned ALU_AND    = 2;
  localparam int unsigned ALU_LSHIFT = 3;
  localparam int unsigned ALU_CMP    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_if
//  Purpose  : Requester-side request/response bundle of the ALU arbiter.
//             master = requesters, slave = arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*OP_W-1:0]   req_op;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_result;
  logic                    rsp_zero;
  logic                    rsp_eq;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_eq
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_eq
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first set bit of
//             req scanning upward from ptr with wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [IDX_W-1:0] ptr,
  output logic      [N_REQ-1:0] grant,
  output logic      [IDX_W-1:0] idx,
  output logic                  any
);

  int pos;

  // Scan from the pointer upward; the first valid index found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = (int'(ptr) + k) % N_REQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one combinational ALU between N_REQ
//             requesters. Grant -> one EXEC cycle -> registered response
//             held until the owning requester accepts it.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = 3,
  parameter int N_REQ  = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  alu_arbiter_if.slave           bus,
  output logic      [DATA_W-1:0] alu_a,
  output logic      [DATA_W-1:0] alu_b,
  output logic      [OP_W-1:0]   alu_op,
  input  wire logic [DATA_W-1:0] alu_result,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_eq;

  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_grant_ok;
  logic [IDX_W-1:0]  w_ptr_next;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [OP_W-1:0]   w_sel_op;
  logic              w_eq;
  logic [DATA_W-1:0] w_res;
  logic              w_rsp_hs;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (w_grant),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  // A grant only happens from IDLE, and never while flush or reset is high.
  assign w_grant_ok    = (state == ST_IDLE) && !flush && !rst && w_pick_any;
  assign bus.req_ready = w_grant_ok ? w_grant : '0;

  assign w_ptr_next = (w_pick_idx == IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
  assign w_sel_a    = bus.req_a[w_pick_idx*DATA_W +: DATA_W];
  assign w_sel_b    = bus.req_b[w_pick_idx*DATA_W +: DATA_W];
  assign w_sel_op   = bus.req_op[w_pick_idx*OP_W +: OP_W];

  // Equality is computed here for every opcode; CMP replaces the ALU result.
  assign w_eq  = (r_a == r_b);
  assign w_res = (r_op == OP_W'(ALU_CMP)) ? {{(DATA_W-1){1'b0}}, w_eq} : alu_result;

  assign w_rsp_hs = bus.rsp_ready[r_idx];

  assign alu_a          = r_a;
  assign alu_b          = r_b;
  assign alu_op         = r_op;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_eq     = r_eq;
  assign busy           = (state != ST_IDLE);

  // Arbitration FSM: grant in IDLE, capture in EXEC, hold response in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_eq        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (w_grant_ok) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_op  <= w_sel_op;
            r_idx <= w_pick_idx;
            ptr   <= w_ptr_next;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_eq        <= w_eq;
            r_rsp_valid <= N_REQ'(1) << r_idx;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // flush wins over a same-cycle handshake; both just drop the response
          if (flush || w_rsp_hs) begin
            r_rsp_valid <= '0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed self-checking bench for alu_arbiter with a simple
//             behavioural ALU attached to the arbiter's ALU port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int OW = 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_result;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OP_W(OW)) bus ();

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; CMP returns a junk pattern the arbiter must override.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a << alu_b[4:0];
      3'd4:    alu_result = 32'hA5A5_A5A5;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_op[i*OW +: OW] = op;
  endtask

  // One complete transaction from requester i with an immediate response accept.
  task automatic do_op(input string tag, input int i, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [OW-1:0] op,
                       input logic [DW-1:0] e_res, input logic e_zero, input logic e_eq);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    set_req(i, a, b, op);
    bus.req_valid = oh;
    #1 chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(oh));
    tick();
    bus.req_valid = '0;
    #1 chk({tag, ".exec_busy"}, 64'(busy), 64'(1));
    chk({tag, ".exec_alu_a"}, 64'(alu_a), 64'(a));
    chk({tag, ".exec_alu_op"}, 64'(alu_op), 64'(op));
    chk({tag, ".exec_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    tick();
    #1 chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
    chk({tag, ".rsp_result"}, 64'(bus.rsp_result), 64'(e_res));
    chk({tag, ".rsp_zero"}, 64'(bus.rsp_zero), 64'(e_zero));
    chk({tag, ".rsp_eq"}, 64'(bus.rsp_eq), 64'(e_eq));
    bus.rsp_ready = oh;
    tick();
    bus.rsp_ready = '0;
    #1 chk({tag, ".after_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, ".after_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '0;

    // Reset values, with requests pending to show no grant leaks out.
    tick();
    tick();
    #1 chk("reset.req_ready", 64'(bus.req_ready), 64'(0));
    chk("reset.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset.rsp_result", 64'(bus.rsp_result), 64'(0));
    chk("reset.rsp_zero", 64'(bus.rsp_zero), 64'(0));
    chk("reset.rsp_eq", 64'(bus.rsp_eq), 64'(0));
    chk("reset.alu_a", 64'(alu_a), 64'(0));
    chk("reset.alu_op", 64'(alu_op), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    rst = 1'b0;
    bus.req_valid = '0;
    tick();

    // Single ADD from requester 0: 5 + 7.
    do_op("add", 0, 32'd5, 32'd7, 3'd0, 32'd12, 1'b0, 1'b0);

    // CMP equal / not equal, from requester 1 (pointer now at 1).
    do_op("cmp_eq", 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd4, 32'd1, 1'b0, 1'b1);
    do_op("cmp_ne", 1, 32'hDEAD_BEEF, 32'd0, 3'd4, 32'd0, 1'b1, 1'b0);

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    set_req(0, 32'd9, 32'd9, 3'd1);
    set_req(1, 32'hF0, 32'h0F, 3'd2);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr.req_ready", 64'(bus.req_ready), 64'(N'(1) << (k % 2)));
      tick();
      #1 chk("rr.exec_req_ready", 64'(bus.req_ready), 64'(0));
      tick();
      #1 chk("rr.rsp_valid", 64'(bus.rsp_valid), 64'(N'(1) << (k % 2)));
      chk("rr.rsp_result", 64'(bus.rsp_result), 64'(0));
      chk("rr.rsp_zero", 64'(bus.rsp_zero), 64'(1));
      chk("rr.rsp_eq", 64'(bus.rsp_eq), 64'((k % 2) == 0));
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    tick();

    // Backpressure on requester 1: response held, no grants while stalled.
    set_req(1, 32'd3, 32'd4, 3'd0);
    bus.req_valid = 2'b10;
    #1 chk("bp.req_ready", 64'(bus.req_ready), 64'(2'b10));
    tick();
    set_req(0, 32'd1, 32'd1, 3'd0);
    bus.req_valid = 2'b11;
    tick();
    bus.rsp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp.hold_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
      chk("bp.hold_rsp_result", 64'(bus.rsp_result), 64'(7));
      chk("bp.hold_req_ready", 64'(bus.req_ready), 64'(0));
      tick();
    end
    bus.rsp_ready = 2'b10;
    #1 chk("bp.hs_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
    tick();
    bus.rsp_ready = '0;
    #1 chk("bp.next_grant", 64'(bus.req_ready), 64'(2'b01));

    // Flush during EXEC of the requester-0 op just granted.
    tick();
    bus.req_valid = '0;
    flush = 1'b1;
    #1 chk("flush_exec.busy", 64'(busy), 64'(1));
    tick();
    flush = 1'b0;
    #1 chk("flush_exec.idle", 64'(busy), 64'(0));
    chk("flush_exec.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    tick();
    #1 chk("flush_exec.no_rsp", 64'(bus.rsp_valid), 64'(0));

    // Flush during RESP together with rsp_ready.
    set_req(1, 32'd10, 32'd3, 3'd1);
    bus.req_valid = 2'b10;
    #1 chk("flush_resp.req_ready", 64'(bus.req_ready), 64'(2'b10));
    tick();
    bus.req_valid = '0;
    tick();
    #1 chk("flush_resp.rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
    chk("flush_resp.rsp_result", 64'(bus.rsp_result), 64'(7));
    flush = 1'b1;
    bus.rsp_ready = 2'b10;
    tick();
    flush = 1'b0;
    bus.rsp_ready = '0;
    #1 chk("flush_resp.dropped", 64'(bus.rsp_valid), 64'(0));
    chk("flush_resp.idle", 64'(busy), 64'(0));
    tick();
    #1 chk("flush_resp.no_rsp", 64'(bus.rsp_valid), 64'(0));

    // Flush in IDLE suppresses the grant; then a normal LSHIFT completes.
    set_req(0, 32'd1, 32'd4, 3'd3);
    bus.req_valid = 2'b01;
    flush = 1'b1;
    #1 chk("flush_idle.req_ready", 64'(bus.req_ready), 64'(0));
    tick();
    flush = 1'b0;
    #1 chk("flush_idle.busy", 64'(busy), 64'(0));
    do_op("lshift", 0, 32'd1, 32'd4, 3'd3, 32'd16, 1'b0, 1'b0);

    // Undefined opcode 7: ALU returns 0, eq still reported.
    do_op("op7", 0, 32'd5, 32'd5, 3'd7, 32'd0, 1'b1, 1'b1);

    // Reset in RESP with pointer at 1.
    set_req(0, 32'd2, 32'd2, 3'd0);
    bus.req_valid = 2'b01;
    #1 chk("rst_resp.req_ready", 64'(bus.req_ready), 64'(2'b01));
    tick();
    bus.req_valid = '0;
    tick();
    #1 chk("rst_resp.rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    chk("rst_resp.rsp_result", 64'(bus.rsp_result), 64'(4));
    rst = 1'b1;
    tick();
    #1 chk("rst_resp.after_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_resp.after_result", 64'(bus.rsp_result), 64'(0));
    chk("rst_resp.after_eq", 64'(bus.rsp_eq), 64'(0));
    chk("rst_resp.after_alu_a", 64'(alu_a), 64'(0));
    chk("rst_resp.after_alu_b", 64'(alu_b), 64'(0));
    chk("rst_resp.after_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    set_req(0, 32'd8, 32'd1, 3'd1);
    set_req(1, 32'd6, 32'd6, 3'd0);
    bus.req_valid = 2'b11;
    #1 chk("rst_resp.first_grant", 64'(bus.req_ready), 64'(2'b01));
    tick();
    bus.req_valid = '0;
    #1 chk("rst_resp.exec_alu_a", 64'(alu_a), 64'(8));
    tick();
    #1 chk("rst_resp.new_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    chk("rst_resp.new_result", 64'(bus.rsp_result), 64'(7));
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = '0;
    #1 chk("rst_resp.done", 64'(bus.rsp_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between N_REQ requesters, e.g. execute stage, branch-compare unit and address generator.
- Each requester presents an operation with a valid/ready handshake. The block grants round-robin, latches the operands, drives the ALU for one cycle, registers the result and returns it to the granted requester.
- Sits between the pipeline issue logic and the ALU instance. It owns the ALU input muxing.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 3, ALU opcode width (ADD=0, SUB=1, AND=2, LSHIFT=3, CMP=4)
- N_REQ, 2, number of requesters; supported 2..4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  abandon the in-flight operation; no response is returned
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot; request accepted when valid&ready
- req_a  in  N_REQ*DATA_W  packed operand A; requester i at [i*DATA_W +: DATA_W]
- req_b  in  N_REQ*DATA_W  packed operand B
- req_op  in  N_REQ*OP_W  packed opcode
- alu_a  out  DATA_W  to ALU operand A
- alu_b  out  DATA_W  to ALU operand B
- alu_op  out  OP_W  to ALU control
- alu_result  in  DATA_W  from ALU, combinational
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_ready  in  N_REQ  per-requester response accept
- rsp_result  out  DATA_W  registered result; for CMP = {DATA_W-1 zeros, eq}
- rsp_zero  out  1  registered (result == 0), computed in this block
- rsp_eq  out  1  registered (a == b), computed in this block for every op
- busy  out  1  high in EXEC or RESP

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_eq=0, alu_a/alu_b/alu_op=0, busy=0.
- IDLE:
  - req_ready is one-hot to the winner among req_valid, combinational from req_valid and the pointer.
  - Winner = first valid index scanning from pointer upward, with wrap.
  - If any request is valid, latch its a/b/op and index, then go to EXEC.
  - The pointer advances to winner+1 mod N_REQ on the grant.
- EXEC (one cycle):
  - alu_a/alu_b/alu_op are driven from the latched registers. They are registered outputs, stable throughout EXEC and RESP.
  - At the end of the cycle, capture alu_result; for CMP capture {0, eq} instead. Capture zero and eq, then go to RESP.
- RESP:
  - rsp_valid[idx] is held high; rsp_* stay stable until rsp_ready[idx].
  - On handshake, return to IDLE. No new grant is issued in the handshake cycle.
- Latency and throughput:
  - Accept at cycle N, rsp_valid at N+2.
  - Minimum spacing between grants is 3 cycles.
- req_ready=0 in EXEC and RESP. A requester may drop req_valid while not granted.
- Opcode 5..7 is passed to the ALU unchanged. The result is whatever the ALU returns (0 by ALU default); rsp_eq is still valid.
- LSHIFT: the block does not clip the shift amount; the ALU defines the result.
- flush:
  - In EXEC or RESP: go to IDLE next cycle, rsp_valid drops, captured data is discarded.
  - In IDLE: suppresses the grant (req_ready=0) that cycle.
  - flush has priority over rsp_ready in the same cycle.
- rst mid-operation has the same effect as flush, and also resets the pointer and all registers to reset values.
- rsp_ready on a non-granted index is ignored.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ALU_ADD..ALU_CMP
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2)
  - DATA_W default
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Single request, requester 0, ADD a=5 b=7 -> req_ready[0] at cycle 0; rsp_valid[0] at cycle 2; rsp_result=12, rsp_zero=0, rsp_eq=0.
- Both requesters valid continuously, req0 SUB 9-9, req1 AND 0xF0&0x0F -> grants alternate 0,1,0,1 starting at 0. req0 gets result 0 with zero=1, eq=1; req1 gets 0 with zero=1, eq=0.
- CMP a=0xDEADBEEF b=0xDEADBEEF -> rsp_result=1, rsp_eq=1. Repeat with b=0 -> rsp_result=0, rsp_eq=0.
- Backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid/result held stable; req_ready stays 0 to all; one cycle after handshake a new grant is possible.
- flush asserted in EXEC, then separately in RESP -> no rsp_valid for that op; IDLE next cycle; the next request completes normally. flush together with rsp_ready -> no handshake counted.
- rst asserted in RESP -> next cycle all outputs at reset values and pointer=0; with both requesters valid, the first grant goes to requester 0.
